// File: rtl/byte_serializer_pkg.sv
// Shared types for the byte serializer: byte width, byte type and FSM state encoding.
package byte_serializer_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } ser_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Single-clock show-ahead FIFO. A push while full is taken only if a pop happens on the same edge.
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];

    // Storage carries no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial byte transmitter: 8-entry FIFO feeding an MSB-first shifter framed by write_out.
// Handshake: enqueue_in is a level-sampled valid and status_out is the inverse of ready; a byte is
// taken on every edge with enqueue_in high unless the FIFO is full and not popping on that edge.
module byte_serializer
    import byte_serializer_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int BIT_CYCLES = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   clock1M,
    input  logic                   reset,
    input  byte_t                  data_in,
    input  logic                   enqueue_in,
    output logic                   data_out,
    output logic                   write_out,
    output logic                   status_out,
    output logic                   empty_out,
    output ser_state_t             state,
    output logic [$clog2(DEPTH):0] fill_level
);

    localparam int TMAX = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] BIT_LAST = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

    byte_t         fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic [6:0]    shreg;
    logic [2:0]    bit_idx;
    logic [TW-1:0] timer;

    byte_fifo #(
        .DEPTH(DEPTH),
        .W    (BYTE_W)
    ) u_fifo (
        .clk  (clock1M),
        .rst_n(reset),
        .push (enqueue_in),
        .pop  (pop),
        .wdata(data_in),
        .rdata(fifo_head),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fill_level)
    );

    // A byte is loaded from IDLE, or straight out of GAP at its terminal count.
    assign pop = !fifo_empty &&
                 ((state == IDLE) || ((state == GAP) && (timer == GAP_LAST)));

    assign status_out = fifo_full;
    assign empty_out  = fifo_empty && (state == IDLE);

    // data_out holds the bit on the wire; shreg holds the bits still to be sent, next one in [6].
    // One timer serves both bit hold and inter-byte gap since the phases never overlap.
    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_idx   <= '0;
            timer     <= '0;
            data_out  <= 1'b0;
            write_out <= 1'b0;
        end else if (pop) begin
            state     <= SHIFT;
            shreg     <= fifo_head[6:0];
            bit_idx   <= 3'd7;
            timer     <= '0;
            data_out  <= fifo_head[7];
            write_out <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                end
                SHIFT: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        if (bit_idx == 3'd0) begin
                            state     <= GAP;
                            data_out  <= 1'b0;
                            write_out <= 1'b0;
                        end else begin
                            bit_idx  <= bit_idx - 3'd1;
                            data_out <= shreg[6];
                            shreg    <= {shreg[5:0], 1'b0};
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                GAP: begin
                    if (timer == GAP_LAST) begin
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: a fast lane (BIT_CYCLES=1) and a slow lane (BIT_CYCLES=15) checked by a loopback receiver.
`timescale 1ns/1ps
module tb_byte_serializer;
    import byte_serializer_pkg::*;

    localparam int GAP = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;

    byte_t      din_f = '0;
    logic       enq_f = 1'b0;
    logic       do_f, wo_f, full_f, empty_f;
    ser_state_t st_f;
    logic [3:0] fill_f;

    byte_t      din_s = '0;
    logic       enq_s = 1'b0;
    logic       do_s, wo_s, full_s, empty_s;
    ser_state_t st_s;
    logic [3:0] fill_s;

    int compare_cnt  = 0;
    int mismatch_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_q_slow[$];

    int         bit_cycles[2] = '{1, 15};
    int         hi_len[2]     = '{0, 0};
    int         lo_len[2]     = '{0, 0};
    int         frames_rx[2]  = '{0, 0};
    logic       gap_due[2]    = '{1'b0, 1'b0};
    logic       cur_bit[2]    = '{1'b0, 1'b0};
    logic [7:0] rx[2]         = '{8'h00, 8'h00};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", compare_cnt);
        $fatal(1, "watchdog");
    end

    byte_serializer #(.DEPTH(8), .BIT_CYCLES(1), .GAP_CYCLES(GAP)) dut_fast (
        .clock1M   (clk),
        .reset     (rst_n),
        .data_in   (din_f),
        .enqueue_in(enq_f),
        .data_out  (do_f),
        .write_out (wo_f),
        .status_out(full_f),
        .empty_out (empty_f),
        .state     (st_f),
        .fill_level(fill_f)
    );

    byte_serializer #(.DEPTH(8), .BIT_CYCLES(15), .GAP_CYCLES(GAP)) dut_slow (
        .clock1M   (clk),
        .reset     (rst_n),
        .data_in   (din_s),
        .enqueue_in(enq_s),
        .data_out  (do_s),
        .write_out (wo_s),
        .status_out(full_s),
        .empty_out (empty_s),
        .state     (st_s),
        .fill_level(fill_s)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compare_cnt++;
        if (got !== exp) begin
            mismatch_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- loopback receiver / scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic       w;
        logic       d;
        logic [7:0] e;
        int         left;
        for (int i = 0; i < 2; i++) begin
            w = (i == 0) ? wo_f : wo_s;
            d = (i == 0) ? do_f : do_s;
            if (!rst_n) begin
                hi_len[i]  = 0;
                lo_len[i]  = 0;
                gap_due[i] = 1'b0;
            end else if (w) begin
                if (hi_len[i] == 0 && gap_due[i]) begin
                    check($sformatf("gap_len[%0d]", i), lo_len[i], GAP);
                end
                gap_due[i] = 1'b0;
                if (hi_len[i] % bit_cycles[i] == 0) begin
                    cur_bit[i] = d;
                    rx[i]      = {rx[i][6:0], d};
                end else begin
                    check($sformatf("bit_stable[%0d]", i), d, cur_bit[i]);
                end
                hi_len[i]++;
            end else begin
                check($sformatf("dout_idle[%0d]", i), d, 1'b0);
                if (hi_len[i] != 0) begin
                    frames_rx[i]++;
                    check($sformatf("frame_len[%0d]", i), hi_len[i], 8 * bit_cycles[i]);
                    left = (i == 0) ? exp_q.size() : exp_q_slow.size();
                    check($sformatf("frame_expected[%0d]", i), left != 0, 1'b1);
                    if (left != 0) begin
                        e = (i == 0) ? exp_q.pop_front() : exp_q_slow.pop_front();
                        check($sformatf("rx_byte[%0d]", i), rx[i], e);
                        gap_due[i] = (left > 1);
                    end
                    hi_len[i] = 0;
                    lo_len[i] = 1;
                end else begin
                    lo_len[i]++;
                end
            end
        end
    end

    // ---------------- driver tasks (called at posedge + 1ns) ----------------
    task automatic enqueue_fast(input byte_t b, input logic expect_tx);
        din_f = b;
        enq_f = 1'b1;
        if (expect_tx) exp_q.push_back(b);
        @(posedge clk);
        #1;
        enq_f = 1'b0;
    endtask

    task automatic wait_drain(input int lane, input int budget);
        int  n;
        logic busy;
        n    = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            if (lane == 0) busy = !(empty_f && exp_q.size() == 0);
            else           busy = !(empty_s && exp_q_slow.size() == 0);
            if (busy) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check($sformatf("drain_in_budget[%0d]", lane), n < budget, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [7:0] pat;
        logic [7:0] burst[4] = '{8'hAA, 8'hCC, 8'hF0, 8'h0F};
        logic [7:0] ovf[10]  = '{8'hAA, 8'hCC, 8'hF0, 8'h0F, 8'h33,
                                 8'h55, 8'h99, 8'hFF, 8'h00, 8'h5A};
        int         f0;
        int         n;

        // Reset values
        #1 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_dout_wout", {do_f, wo_f, do_s, wo_s}, 4'b0000);
        check("rst_status", {full_f, full_s}, 2'b00);
        check("rst_empty", {empty_f, empty_s}, 2'b11);
        check("rst_state", st_f, IDLE);
        check("rst_fill", fill_f, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            check("idle_quiet", {wo_f, do_f, wo_s, do_s, full_f, empty_f, empty_s}, 7'b0000011);
        end

        // Single byte, exact timing
        pat = 8'hAA;
        din_f = pat;
        enq_f = 1'b1;
        exp_q.push_back(pat);
        @(posedge clk);
        #1;
        enq_f = 1'b0;
        check("wo_not_yet", wo_f, 1'b0);
        check("empty_after_push", empty_f, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("single_wo", wo_f, 1'b1);
            check("single_bit", do_f, pat[7-k]);
        end
        @(posedge clk);
        #1;
        check("single_wo_fall", wo_f, 1'b0);
        @(posedge clk);
        #1;
        check("empty_in_gap", empty_f, 1'b0);
        check("state_gap", st_f, GAP);
        @(posedge clk);
        #1;
        check("empty_after_gap", empty_f, 1'b1);
        check("single_rx_done", exp_q.size(), 0);

        // Burst of four back-to-back bytes
        f0 = frames_rx[0];
        for (int k = 0; k < 4; k++) enqueue_fast(burst[k], 1'b1);
        wait_drain(0, 100);
        check("burst_frames", frames_rx[0] - f0, 4);

        // Overflow on the slow lane: 8 held plus one absorbed by the first pop
        f0 = frames_rx[1];
        for (int k = 0; k < 10; k++) begin
            din_s = ovf[k];
            enq_s = 1'b1;
            if (k < 9) exp_q_slow.push_back(ovf[k]);
            @(posedge clk);
            #1;
            check($sformatf("status_after_push%0d", k), full_s, (k >= 8) ? 1'b1 : 1'b0);
        end
        enq_s = 1'b0;
        check("fill_full", fill_s, 4'd8);

        // Push 3C on the edge the FSM pops from a full FIFO
        n = 0;
        while (wo_s && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("first_fall_seen", n < 200, 1'b1);
        check("full_before_simul", full_s, 1'b1);
        @(posedge clk);
        #1;
        din_s = 8'h3C;
        enq_s = 1'b1;
        exp_q_slow.push_back(8'h3C);
        @(posedge clk);
        #1;
        enq_s = 1'b0;
        check("simul_popped", wo_s, 1'b1);
        check("simul_fill", fill_s, 4'd8);
        check("simul_status", full_s, 1'b1);
        wait_drain(1, 1500);
        check("ovf_frames", frames_rx[1] - f0, 10);

        // Reset in the middle of byte CC with three bytes queued
        @(posedge clk);
        #1;
        enqueue_fast(8'hCC, 1'b0);
        enqueue_fast(8'h11, 1'b0);
        enqueue_fast(8'h22, 1'b0);
        enqueue_fast(8'h33, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_reset_wo", wo_f, 1'b1);
        check("pre_reset_bit3", do_f, 1'b1);
        check("pre_reset_fill", fill_f, 4'd3);
        rst_n = 1'b0;
        #1;
        check("midrst_wo_dout", {wo_f, do_f}, 2'b00);
        check("midrst_empty", empty_f, 1'b1);
        check("midrst_fill", fill_f, 4'd0);
        check("midrst_state", st_f, IDLE);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        f0 = frames_rx[0];
        enqueue_fast(8'h5A, 1'b1);
        wait_drain(0, 100);
        check("post_reset_frames", frames_rx[0] - f0, 1);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
        $finish;
    end

endmodule

// File: doc/byte_serializer.md
# byte_serializer

Transmit-side counterpart of the serial byte receiver. Accepts parallel bytes from a local producer into an 8-entry FIFO and shifts each byte out MSB-first on a single data line, framed by a write strobe. The serial output follows the receiver's input protocol, so `data_out` and `write_out` connect directly to a receiver's `data_in` and `write_in`.

## Interface

- `DEPTH`, 8: FIFO entries, power of two.
- `BIT_CYCLES`, 1: clock cycles each serial bit is held, ≥1.
- `GAP_CYCLES`, 2: minimum cycles `write_out` stays low between bytes, ≥1.

- `clock1M`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous reset, active-low.
- `data_in`  in  8  byte to enqueue.
- `enqueue_in`  in  1  push `data_in` on this edge; level-sampled, one byte per cycle high.
- `data_out`  out  1  serial bit, MSB first.
- `write_out`  out  1  high for exactly 8×BIT_CYCLES cycles per byte.
- `status_out`  out  1  FIFO full.
- `empty_out`  out  1  FIFO empty and shifter idle.

## Operation

- FIFO
  - Push when `enqueue_in`=1 and not full.
  - Push while full is dropped silently; the count does not change.
  - Push and pop on the same edge while full: both happen and the count is unchanged.
  - Pointers wrap modulo DEPTH. The count is $clog2(DEPTH)+1 bits wide.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: if the FIFO is non-empty, pop its head into `shreg`, drive `data_out`=`shreg[7]`, set `write_out`=1, and go to SHIFT. Bit index = 7, bit timer = 0.
  - SHIFT: the bit timer counts to BIT_CYCLES−1. At terminal count:
    - If bit index = 0: `write_out`←0, `data_out`←0, go to GAP.
    - Otherwise: shift left, decrement the index, and present the next bit.
  - GAP: the timer counts to GAP_CYCLES−1. At terminal count:
    - FIFO non-empty: pop and enter SHIFT on the same edge, following the same load rule as IDLE.
    - FIFO empty: go to IDLE.
- `data_out` and `write_out` are registered. `data_out` is 0 whenever `write_out`=0.
- `status_out` = (count == DEPTH), combinational from the count.
- `empty_out` = (count == 0) && state == IDLE.
- Reset (async, low): FIFO pointers and count cleared, state IDLE, timers 0.
  - Outputs during reset: `data_out`=0, `write_out`=0, `status_out`=0, `empty_out`=1.
  - Reset mid-byte truncates the frame immediately; the partial byte and all queued bytes are discarded.

## Timing

- Enqueue at edge N into an empty, idle block:
  - Pop at edge N+1.
  - `write_out` is high from N+1 through edge N+1+8×BIT_CYCLES.
- MSB is valid on `data_out` in the same cycle `write_out` rises. Each bit is stable for exactly BIT_CYCLES cycles.
- Back-to-back bytes: `write_out` is low for exactly GAP_CYCLES cycles between frames when the FIFO stays non-empty.
- Byte period = 8×BIT_CYCLES + GAP_CYCLES cycles. With defaults this is 10 cycles.
- `status_out` updates the cycle after the edge that changes the count.
- An enqueue on the same edge as a pop from a full FIFO is accepted.

## Structure

- Package `byte_serializer_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, SHIFT, GAP} ser_state_t`
  - `localparam int BYTE_W = 8`
  - `typedef logic [BYTE_W-1:0] byte_t`
- Sub-module `byte_fifo` (params DEPTH, W):
  - Synchronous single-clock FIFO, same async active-low reset.
  - Ports: push, pop, wdata, rdata (head, show-ahead), full, empty, count.
- Top level `byte_serializer` contains the FSM, shift register, bit and gap timers, and the output registers.

## Test plan

- **Reset values.** Hold `reset`=0 for 5 cycles, then release.
  - During and after reset: `data_out`=0, `write_out`=0, `status_out`=0, `empty_out`=1.
  - No activity for 50 cycles after release.
- **Single byte.** Enqueue 8'hAA once.
  - `write_out` high for 8 cycles starting 1 cycle after the push.
  - `data_out` sequence is 1,0,1,0,1,0,1,0.
  - `empty_out` returns to 1 after the gap.
- **Burst.** Enqueue AA, CC, F0, 0F on consecutive cycles.
  - Four frames in order, separated by exactly GAP_CYCLES low cycles.
  - A loopback receiver dequeues AA, CC, F0, 0F.
- **Full / overflow.** With BIT_CYCLES=15, enqueue 10 bytes in consecutive cycles: AA, CC, F0, 0F, 33, 55, 99, FF, 00, 5A.
  - `status_out` rises when 8 entries are held; at most one extra byte is absorbed by the first pop.
  - Later bytes are dropped.
  - Transmitted sequence is exactly the accepted bytes, in order.
- **Simultaneous push/pop at full.** Full FIFO; push 8'h3C on the edge the FSM pops.
  - Count stays 8 and 3C is transmitted last.
- **Reset mid-frame.** Assert `reset` low during bit 3 of byte CC with 3 bytes queued.
  - `write_out` and `data_out` go to 0 immediately and `empty_out`=1.
  - After release, the next enqueued byte is transmitted cleanly.
